// File: rtl/qdec_pkg.sv
// Quadrature decoder shared constants.
// Phase encodings and the up-sequence helper.
package qdec_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Next phase when moving up (A leads B).
  function automatic logic [1:0] next_up(
    input logic [1:0] ph
  );
    logic [1:0] r;
    r = PH_00;
    unique case (ph)
      PH_00:   r = PH_10;
      PH_10:   r = PH_11;
      PH_11:   r = PH_01;
      PH_01:   r = PH_00;
      default: r = PH_00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// Input synchronizer for both quadrature channels.
// Optional stability filter under QDEC_GLITCH_FILTER_EN.
module qdec_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  output logic [1:0] s,
  output logic       valid
);

  logic [1:0] meta;
  logic [1:0] sync;
  logic [1:0] vld;

  // Two-flop synchronizer; vld marks stages holding real samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      vld  <= '0;
    end else begin
      meta <= {quad_a, quad_b};
      sync <= meta;
      vld  <= {vld[0], 1'b1};
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  logic [1:0] h0;
  logic [1:0] h1;
  logic [1:0] hv;
  logic [1:0] hold;
  logic       acc;
  logic       stable;

  assign stable = hv[1] && (sync == h0) && (h0 == h1);

  // Accept a sample only after three identical consecutive values.
  always_ff @(posedge clk) begin
    if (reset) begin
      h0   <= '0;
      h1   <= '0;
      hv   <= '0;
      hold <= '0;
      acc  <= 1'b0;
    end else begin
      h0 <= sync;
      h1 <= h0;
      hv <= {hv[0], vld[1]};
      if (stable) begin
        hold <= sync;
        acc  <= 1'b1;
      end
    end
  end

  assign s     = stable ? sync : hold;
  assign valid = stable | acc;
`else
  assign s     = sync;
  assign valid = vld[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: position count, step/dir, error flag.
// Build option: QDEC_GLITCH_FILTER_EN adds an input filter.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  input  logic             clear,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [1:0] s;
  logic [1:0] p;
  logic       s_valid;
  logic       primed;
  logic       is_up;
  logic       is_dn;

  qdec_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .s      (s),
    .valid  (s_valid)
  );

  assign is_up = (s == next_up(p));
  assign is_dn = (p == next_up(s));

  // Decode phase changes into step/dir/count and errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      p      <= PH_00;
      primed <= 1'b0;
      step   <= 1'b0;
      dir    <= 1'b0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clear) begin
        count <= '0;
        err   <= 1'b0;
        if (s_valid) begin
          p      <= s;
          primed <= 1'b1;
        end
      end else if (s_valid) begin
        p      <= s;
        primed <= 1'b1;
        if (primed && (s != p)) begin
          if (is_up) begin
            if (enable) begin
              step  <= 1'b1;
              dir   <= 1'b1;
              count <= count + ONE;
            end
          end else if (is_dn) begin
            if (enable) begin
              step  <= 1'b1;
              dir   <= 1'b0;
              count <= count - ONE;
            end
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder.
// Scoreboard of expected steps checked by a monitor.
module tb_quad_decoder;

  localparam int CNT_W = 8;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic quad_a = 1'b0;
  logic quad_b = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic step;
  logic dir;
  logic err;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;
  int steps_seen = 0;

  exp_t q[$];
  exp_t mon_e;
  logic [1:0] mp;
  logic [CNT_W-1:0] mcount;

  always #5 clk = ~clk;

  quad_decoder #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .enable (enable),
    .clear  (clear),
    .step   (step),
    .dir    (dir),
    .count  (count),
    .err    (err)
  );

  // Pop the scoreboard on every step pulse.
  always @(negedge clk) begin
    if (!reset && step) begin
      steps_seen++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_step got count=%0d dir=%0b required no step",
                 count, dir);
      end else begin
        mon_e = q.pop_front();
        if (dir !== mon_e.dir || count !== mon_e.count) begin
          failures++;
          $display("FAIL step_value got dir=%0b count=%0d required dir=%0b count=%0d",
                   dir, count, mon_e.dir, mon_e.count);
        end
      end
    end
  end

  function automatic bit up_tr(input logic [1:0] a, input logic [1:0] b);
    case ({a, b})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1;
    clear = 1'b0;
    {quad_a, quad_b} = ab;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mp = ab;
    mcount = '0;
    q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] ab, input int hold);
    @(negedge clk);
    {quad_a, quad_b} = ab;
    if (ab != mp) begin
      if (up_tr(mp, ab)) begin
        if (enable) begin
          mcount++;
          q.push_back({1'b1, mcount});
        end
      end else if (up_tr(ab, mp)) begin
        if (enable) begin
          mcount--;
          q.push_back({1'b0, mcount});
        end
      end
    end
    mp = ab;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    {quad_a, quad_b} = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got %0d required 0", count);
    end
    checks++;
    if (step !== 1'b0) begin
      failures++;
      $display("FAIL reset_step got %0b required 0", step);
    end
    checks++;
    if (dir !== 1'b0) begin
      failures++;
      $display("FAIL reset_dir got %0b required 0", dir);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got %0b required 0", err);
    end
  endtask

  task automatic test_forward;
    int s0;
    enable = 1'b1;
    do_reset(2'b00);
    s0 = steps_seen;
    move(2'b10, 8);
    move(2'b11, 8);
    move(2'b01, 8);
    move(2'b00, 8);
    checks++;
    if (steps_seen - s0 !== 4) begin
      failures++;
      $display("FAIL fwd_steps got %0d required 4", steps_seen - s0);
    end
    checks++;
    if (count !== 8'd4) begin
      failures++;
      $display("FAIL fwd_count got %0d required 4", count);
    end
    checks++;
    if (dir !== 1'b1) begin
      failures++;
      $display("FAIL fwd_dir got %0b required 1", dir);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL fwd_err got %0b required 0", err);
    end
  endtask

  task automatic test_wrap;
    do_reset(2'b00);
    move(2'b01, 8);
    checks++;
    if (count !== 8'd255) begin
      failures++;
      $display("FAIL wrap_down_count got %0d required 255", count);
    end
    checks++;
    if (dir !== 1'b0) begin
      failures++;
      $display("FAIL wrap_down_dir got %0b required 0", dir);
    end
    move(2'b00, 8);
    move(2'b10, 8);
    checks++;
    if (count !== 8'd1) begin
      failures++;
      $display("FAIL wrap_up_count got %0d required 1", count);
    end
  endtask

  task automatic test_latency;
    int edges;
    do_reset(2'b00);
    edges = 0;
    @(negedge clk);
    quad_a = 1'b1;
    mcount++;
    q.push_back({1'b1, mcount});
    mp = 2'b10;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (step) break;
    end
    checks++;
    if (edges !== LAT) begin
      failures++;
      $display("FAIL latency got %0d edges required %0d", edges, LAT);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_err;
    int s0;
    do_reset(2'b00);
    move(2'b10, 8);
    s0 = steps_seen;
    move(2'b01, 8);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got %0b required 1", err);
    end
    checks++;
    if (count !== 8'd1 || steps_seen != s0) begin
      failures++;
      $display("FAIL err_hold got count=%0d steps=%0d required 1 and 0",
               count, steps_seen - s0);
    end
    move(2'b00, 8);
    checks++;
    if (err !== 1'b1 || count !== 8'd2) begin
      failures++;
      $display("FAIL err_sticky got err=%0b count=%0d required 1 and 2",
               err, count);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mcount = '0;
    checks++;
    if (err !== 1'b0 || count !== 8'd0 || step !== 1'b0) begin
      failures++;
      $display("FAIL clear got err=%0b count=%0d step=%0b required 0 0 0",
               err, count, step);
    end
    s0 = steps_seen;
    @(negedge clk);
    quad_a = 1'b1;
    mp = 2'b10;
    repeat (LAT - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (count !== 8'd0 || steps_seen != s0 || err !== 1'b0) begin
      failures++;
      $display("FAIL clear_override got count=%0d steps=%0d err=%0b required 0 0 0",
               count, steps_seen - s0, err);
    end
    move(2'b11, 8);
    checks++;
    if (count !== 8'd1) begin
      failures++;
      $display("FAIL after_clear got %0d required 1", count);
    end
  endtask

  task automatic test_enable;
    int s0;
    do_reset(2'b00);
    s0 = steps_seen;
    enable = 1'b0;
    move(2'b10, 8);
    move(2'b11, 8);
    move(2'b01, 8);
    checks++;
    if (count !== 8'd0 || steps_seen != s0) begin
      failures++;
      $display("FAIL en_off got count=%0d steps=%0d required 0 0",
               count, steps_seen - s0);
    end
    enable = 1'b1;
    move(2'b00, 8);
    checks++;
    if (count !== 8'd1 || steps_seen - s0 != 1) begin
      failures++;
      $display("FAIL en_on got count=%0d steps=%0d required 1 1",
               count, steps_seen - s0);
    end
  endtask

  task automatic test_prime;
    int s0;
    s0 = steps_seen;
    do_reset(2'b11);
    checks++;
    if (err !== 1'b0 || count !== 8'd0 || steps_seen != s0) begin
      failures++;
      $display("FAIL prime got err=%0b count=%0d steps=%0d required 0 0 0",
               err, count, steps_seen - s0);
    end
    move(2'b01, 8);
    checks++;
    if (count !== 8'd1 || dir !== 1'b1) begin
      failures++;
      $display("FAIL prime_next got count=%0d dir=%0b required 1 1",
               count, dir);
    end
  endtask

  task automatic test_midreset;
    int s0;
    do_reset(2'b00);
    move(2'b10, 8);
    @(negedge clk);
    {quad_a, quad_b} = 2'b11;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mp = 2'b11;
    mcount = '0;
    q.delete();
    s0 = steps_seen;
    repeat (10) @(negedge clk);
    checks++;
    if (count !== 8'd0 || err !== 1'b0 || steps_seen != s0) begin
      failures++;
      $display("FAIL midreset got count=%0d err=%0b steps=%0d required 0 0 0",
               count, err, steps_seen - s0);
    end
  endtask

`ifdef QDEC_GLITCH_FILTER_EN
  task automatic test_glitch;
    int s0;
    do_reset(2'b00);
    s0 = steps_seen;
    @(negedge clk);
    quad_a = 1'b1;
    repeat (2) @(negedge clk);
    quad_a = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (count !== 8'd0 || err !== 1'b0 || steps_seen != s0) begin
      failures++;
      $display("FAIL glitch got count=%0d err=%0b steps=%0d required 0 0 0",
               count, err, steps_seen - s0);
    end
  endtask
`endif

  initial begin
    mp = 2'b00;
    mcount = '0;
    test_reset();
    test_forward();
    test_wrap();
    test_latency();
    test_err();
    test_enable();
    test_prime();
    test_midreset();
`ifdef QDEC_GLITCH_FILTER_EN
    test_glitch();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_steps got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of the position counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 quad_a  input  1  asynchronous quadrature channel A.
REQ-005 quad_b  input  1  asynchronous quadrature channel B.
REQ-006 enable  input  1  when 1, valid transitions are counted; when 0, they are tracked but not counted.
REQ-007 clear  input  1  synchronous clear of count and err.
REQ-008 step  output  1  one-cycle pulse per counted transition; drives a counter enable.
REQ-009 dir  output  1  direction of last counted transition (1=up, 0=down); drives a counter up/down select.
REQ-010 count  output  CNT_W  position counter.
REQ-011 err  output  1  sticky illegal-transition flag.

Function
REQ-012 quad_a/quad_b SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Synced state S={A,B}; prev register P holds the last accepted S.
REQ-014 Up sequence SHALL be 00->10->11->01->00 (A leads B); the reverse is down.
REQ-015 S==P SHALL produce no action.
REQ-016 Single-bit change in the up/down order with enable=1: step=1 for exactly one cycle, dir set accordingly, count +/-1, P<=S, all on the same edge.
REQ-017 Single-bit change with enable=0: P<=S, no step, count and dir held.
REQ-018 Both bits changing (00<->11, 10<->01): err<=1, P<=S, no step, count held, regardless of enable.
REQ-019 Latency: pin edge to step/count update SHALL be 3 clk edges (2 sync + 1 decode) without the filter.
REQ-020 count SHALL wrap modulo 2^CNT_W: max+1 -> 0, 0-1 -> max.
REQ-021 clear=1: count<=0, err<=0, step<=0, P<=S; no step for that cycle even if a transition is present; clear overrides enable and err-set.
REQ-022 Priming: after reset, a primed flag SHALL be 0; the first decode cycle loads P<=S, sets primed, and produces no step and no err.
REQ-023 err SHALL stay 1 until clear or reset.

Reset
REQ-024 On reset=1 at a clk edge: count=0, step=0, dir=0, err=0, sync flops=0, P=00, primed=0, filter state=0.
REQ-025 Reset asserted mid-sequence SHALL discard all in-flight samples; no step SHALL be issued in the cycle following reset release.

Configuration
REQ-026 Macro QDEC_GLITCH_FILTER_EN: when defined, synced S SHALL be accepted only after it has been identical for 3 consecutive clk samples; latency becomes 5 edges; pulses shorter than 3 cycles SHALL be ignored.
REQ-027 When QDEC_GLITCH_FILTER_EN is undefined, no filter logic SHALL be present, and latency is per REQ-019.

Structure
REQ-028 Package qdec_pkg SHALL hold the four 2-bit phase constants (PH_00, PH_10, PH_11, PH_01) and the default CNT_W.
REQ-029 Sub-module qdec_sync SHALL contain the 2-flop synchronizer for both channels and, under QDEC_GLITCH_FILTER_EN, the stability filter; quad_decoder instantiates it once.

Verification
REQ-030 After reset, drive AB 00,10,11,01,00 (each held 8 cycles), enable=1 -> 4 step pulses, dir=1, count=4, err=0.
REQ-031 From count=0, drive one reverse step (00->01) -> count=255 (CNT_W=8), dir=0; then two forward steps -> count=1.
REQ-032 Jump AB 00->11 -> err=1, count unchanged, no step; next pulse clear=1 -> err=0, count=0, no step.
REQ-033 enable=0 over 3 forward transitions, then enable=1 plus one forward transition -> exactly 1 step, count=1.
REQ-034 Hold AB=11 through reset release -> no step or err in priming; next transition 11->01 -> count=1.
REQ-035 With QDEC_GLITCH_FILTER_EN, 2-cycle pulse on A -> no step; 4-cycle-stable change -> step 5 edges after the pin edge.
